// File: rtl/forward_hazard_ctrl.sv
// Pipeline hazard/forwarding controller: stall/flush generation, EX operand
// forwarding, multi-cycle memory wait and halt tracking. Optional perf counters under FORWARD_PERF_EN.
module forward_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ID_rs1,
    input  logic [4:0] ID_rs2,
    input  logic       ID_use_rs1,
    input  logic       ID_use_rs2,
    input  logic [4:0] EX_rs1,
    input  logic [4:0] EX_rs2,
    input  logic [4:0] EX_rd,
    input  logic       EX_write_gpr,
    input  logic       EX_mem_to_reg,
    input  logic       EX_redirect,
    input  logic [4:0] ME_rd,
    input  logic       ME_write_gpr,
    input  logic       ME_mem_to_reg,
    input  logic       ME_req,
    input  logic       ME_resp_valid,
    input  logic [4:0] WB_rd,
    input  logic       WB_write_gpr,
    input  logic       WB_commit,
    input  logic       WB_system_halt,
    output logic       FORWARD_stallIF,
    output logic       FORWARD_stallID,
    output logic       FORWARD_stallEX,
    output logic       FORWARD_stallME,
    output logic       FORWARD_stallWB,
    output logic       FORWARD_flushIF,
    output logic       FORWARD_flushID,
    output logic       FORWARD_flushEX,
    output logic       FORWARD_flushME,
    output logic [1:0] FORWARD_rs1_sel,
    output logic [1:0] FORWARD_rs2_sel,
    output logic       mem_timeout,
    output logic       halted
`ifdef FORWARD_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_loaduse,
    output logic [31:0] perf_redirects
`endif
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [1:0] SEL_RF = 2'b00;
    localparam logic [1:0] SEL_ME = 2'b01;
    localparam logic [1:0] SEL_WB = 2'b10;

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    logic [1:0] state_r;
    logic [1:0] state_nxt_s;
    logic [7:0] wait_cnt_r;
    logic [7:0] wait_cnt_nxt_s;
    logic       load_use_s;
    logic       mem_wait_s;
    logic       halt_req_s;
    logic       do_redirect_s;
    logic       do_loaduse_s;

    // ME results are only forwardable for non-loads; x0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       me_we,
        input logic       me_load,
        input logic [4:0] me_rd,
        input logic       wb_we,
        input logic [4:0] wb_rd
    );
        logic [1:0] sel;
        if (me_we && !me_load && (me_rd != 5'd0) && (me_rd == src)) begin
            sel = SEL_ME;
        end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == src)) begin
            sel = SEL_WB;
        end else begin
            sel = SEL_RF;
        end
        return sel;
    endfunction

    // Hazard conditions derived from the current pipeline contents.
    always_comb begin
        load_use_s = EX_mem_to_reg & EX_write_gpr & (EX_rd != 5'd0) &
                     ((ID_use_rs1 & (ID_rs1 == EX_rd)) | (ID_use_rs2 & (ID_rs2 == EX_rd)));
        mem_wait_s = ~ME_resp_valid & (((state_r == ST_RUN) & ME_req) | (state_r == ST_WAIT));
        halt_req_s = WB_commit & WB_system_halt;
    end

    // Stall/flush/status outputs; the response cycle of a wait behaves like RUN.
    always_comb begin
        FORWARD_stallIF = 1'b0;
        FORWARD_stallID = 1'b0;
        FORWARD_stallEX = 1'b0;
        FORWARD_stallME = 1'b0;
        FORWARD_stallWB = 1'b0;
        FORWARD_flushIF = 1'b0;
        FORWARD_flushID = 1'b0;
        FORWARD_flushEX = 1'b0;
        FORWARD_flushME = 1'b0;
        mem_timeout     = 1'b0;
        halted          = 1'b0;
        do_redirect_s   = 1'b0;
        do_loaduse_s    = 1'b0;
        if (rst) begin
            FORWARD_flushIF = 1'b1;
            FORWARD_flushID = 1'b1;
            FORWARD_flushEX = 1'b1;
            FORWARD_flushME = 1'b1;
        end else begin
            case (state_r)
                ST_RUN, ST_WAIT: begin
                    if (mem_wait_s) begin
                        FORWARD_stallIF = 1'b1;
                        FORWARD_stallID = 1'b1;
                        FORWARD_stallEX = 1'b1;
                        FORWARD_stallME = 1'b1;
                        FORWARD_flushME = 1'b1;
                        mem_timeout     = (state_r == ST_WAIT) & (wait_cnt_r == TIMEOUT_C);
                    end else if (EX_redirect) begin
                        FORWARD_flushIF = 1'b1;
                        FORWARD_flushID = 1'b1;
                        do_redirect_s   = 1'b1;
                    end else if (load_use_s) begin
                        FORWARD_stallIF = 1'b1;
                        FORWARD_stallID = 1'b1;
                        FORWARD_flushID = 1'b1;
                        do_loaduse_s    = 1'b1;
                    end else begin
                        do_loaduse_s    = 1'b0;
                    end
                end
                ST_HALT: begin
                    FORWARD_stallIF = 1'b1;
                    FORWARD_stallID = 1'b1;
                    FORWARD_stallEX = 1'b1;
                    FORWARD_stallME = 1'b1;
                    FORWARD_stallWB = 1'b1;
                    FORWARD_flushME = 1'b1;
                    halted          = 1'b1;
                end
                default: begin
                    FORWARD_flushIF = 1'b1;
                    FORWARD_flushID = 1'b1;
                    FORWARD_flushEX = 1'b1;
                    FORWARD_flushME = 1'b1;
                end
            endcase
        end
    end

    // EX operand forwarding selects.
    always_comb begin
        if (rst) begin
            FORWARD_rs1_sel = SEL_RF;
            FORWARD_rs2_sel = SEL_RF;
        end else begin
            FORWARD_rs1_sel = fwd_sel(EX_rs1, ME_write_gpr, ME_mem_to_reg, ME_rd, WB_write_gpr, WB_rd);
            FORWARD_rs2_sel = fwd_sel(EX_rs2, ME_write_gpr, ME_mem_to_reg, ME_rd, WB_write_gpr, WB_rd);
        end
    end

    // Next-state and wait-counter logic; halt commit wins from any state.
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        if (halt_req_s) begin
            state_nxt_s    = ST_HALT;
            wait_cnt_nxt_s = 8'd0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    wait_cnt_nxt_s = 8'd0;
                    if (ME_req && !ME_resp_valid) begin
                        state_nxt_s = ST_WAIT;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_WAIT: begin
                    if (ME_resp_valid) begin
                        state_nxt_s    = ST_RUN;
                        wait_cnt_nxt_s = 8'd0;
                    end else if (wait_cnt_r == TIMEOUT_C) begin
                        wait_cnt_nxt_s = 8'd0;
                    end else begin
                        wait_cnt_nxt_s = wait_cnt_r + 8'd1;
                    end
                end
                ST_HALT: begin
                    state_nxt_s    = ST_HALT;
                    wait_cnt_nxt_s = 8'd0;
                end
                default: begin
                    state_nxt_s    = ST_RUN;
                    wait_cnt_nxt_s = 8'd0;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= 8'd0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
        end
    end

`ifdef FORWARD_PERF_EN
    // Event counters; halt cycles are not counted as stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= 32'd0;
            perf_loaduse      <= 32'd0;
            perf_redirects    <= 32'd0;
        end else begin
            if (FORWARD_stallIF && (state_r != ST_HALT)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (do_loaduse_s) begin
                perf_loaduse <= perf_loaduse + 32'd1;
            end
            if (do_redirect_s) begin
                perf_redirects <= perf_redirects + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_forward_hazard_ctrl.sv
// Self-checking bench for forward_hazard_ctrl: directed test-plan scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_forward_hazard_ctrl;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ID_rs1, ID_rs2, EX_rs1, EX_rs2, EX_rd, ME_rd, WB_rd;
    logic       ID_use_rs1, ID_use_rs2, EX_write_gpr, EX_mem_to_reg, EX_redirect;
    logic       ME_write_gpr, ME_mem_to_reg, ME_req, ME_resp_valid;
    logic       WB_write_gpr, WB_commit, WB_system_halt;
    logic       s_if, s_id, s_ex, s_me, s_wb, f_if, f_id, f_ex, f_me;
    logic [1:0] rs1_sel, rs2_sel;
    logic       mem_timeout, halted;
`ifdef FORWARD_PERF_EN
    logic [31:0] perf_stall_cycles, perf_loaduse, perf_redirects;
    int unsigned m_pstall = 0, m_plu = 0, m_predir = 0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int m_mode   = 0;   // 0 running, 1 waiting on memory, 2 halted
    int m_waited = 0;   // completed wait cycles since entering the wait state

    forward_hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
        .EX_rs1(EX_rs1), .EX_rs2(EX_rs2), .EX_rd(EX_rd), .EX_write_gpr(EX_write_gpr),
        .EX_mem_to_reg(EX_mem_to_reg), .EX_redirect(EX_redirect),
        .ME_rd(ME_rd), .ME_write_gpr(ME_write_gpr), .ME_mem_to_reg(ME_mem_to_reg),
        .ME_req(ME_req), .ME_resp_valid(ME_resp_valid),
        .WB_rd(WB_rd), .WB_write_gpr(WB_write_gpr), .WB_commit(WB_commit),
        .WB_system_halt(WB_system_halt),
        .FORWARD_stallIF(s_if), .FORWARD_stallID(s_id), .FORWARD_stallEX(s_ex),
        .FORWARD_stallME(s_me), .FORWARD_stallWB(s_wb),
        .FORWARD_flushIF(f_if), .FORWARD_flushID(f_id), .FORWARD_flushEX(f_ex),
        .FORWARD_flushME(f_me),
        .FORWARD_rs1_sel(rs1_sel), .FORWARD_rs2_sel(rs2_sel),
        .mem_timeout(mem_timeout), .halted(halted)
`ifdef FORWARD_PERF_EN
        , .perf_stall_cycles(perf_stall_cycles), .perf_loaduse(perf_loaduse),
        .perf_redirects(perf_redirects)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_sel(input logic [4:0] src);
        if (src == 5'd0) return 2'b00;
        if (ME_write_gpr && !ME_mem_to_reg && ME_rd == src) return 2'b01;
        if (WB_write_gpr && WB_rd == src) return 2'b10;
        return 2'b00;
    endfunction

    // Behavioural reference: compare at the falling edge, then advance the model.
    always @(negedge clk) begin
        logic [4:0] e_stall;
        logic [3:0] e_flush;
        logic       e_to, e_halt, lu, waiting;
        e_stall = 5'b00000; e_flush = 4'b0000; e_to = 1'b0; e_halt = 1'b0;
        lu = EX_mem_to_reg && EX_write_gpr && EX_rd != 5'd0 &&
             ((ID_use_rs1 && ID_rs1 == EX_rd) || (ID_use_rs2 && ID_rs2 == EX_rd));
        waiting = 1'b0;
        if (rst) begin
            e_flush = 4'b1111;
        end else if (m_mode == 2) begin
            e_stall = 5'b11111; e_flush = 4'b0001; e_halt = 1'b1;
        end else begin
            waiting = !ME_resp_valid && (m_mode == 1 || ME_req);
            if (waiting) begin
                e_stall = 5'b11110; e_flush = 4'b0001;
                e_to = (m_mode == 1 && m_waited == TMO);
            end else if (EX_redirect) begin
                e_flush = 4'b1100;
            end else if (lu) begin
                e_stall = 5'b11000; e_flush = 4'b0100;
            end
        end
        check("stall", {27'd0, s_if, s_id, s_ex, s_me, s_wb}, {27'd0, e_stall});
        check("flush", {28'd0, f_if, f_id, f_ex, f_me}, {28'd0, e_flush});
        check("rs1_sel", {30'd0, rs1_sel}, {30'd0, rst ? 2'b00 : exp_sel(EX_rs1)});
        check("rs2_sel", {30'd0, rs2_sel}, {30'd0, rst ? 2'b00 : exp_sel(EX_rs2)});
        check("mem_timeout", {31'd0, mem_timeout}, {31'd0, e_to});
        check("halted", {31'd0, halted}, {31'd0, e_halt});
`ifdef FORWARD_PERF_EN
        check("perf_stall", perf_stall_cycles, m_pstall);
        check("perf_loaduse", perf_loaduse, m_plu);
        check("perf_redirect", perf_redirects, m_predir);
        if (rst) begin
            m_pstall = 0; m_plu = 0; m_predir = 0;
        end else if (m_mode != 2) begin
            if (e_stall[4]) m_pstall++;
            if (!waiting && !EX_redirect && lu) m_plu++;
            if (!waiting && EX_redirect) m_predir++;
        end
`endif
        if (rst) begin
            m_mode = 0; m_waited = 0;
        end else if (WB_commit && WB_system_halt) begin
            m_mode = 2;
        end else if (m_mode == 0) begin
            m_waited = 0;
            if (ME_req && !ME_resp_valid) m_mode = 1;
        end else if (m_mode == 1) begin
            if (ME_resp_valid) begin
                m_mode = 0; m_waited = 0;
            end else if (m_waited == TMO) begin
                m_waited = 0;
            end else begin
                m_waited++;
            end
        end
    end

    task automatic idle();
        {ID_rs1, ID_rs2, EX_rs1, EX_rs2, EX_rd, ME_rd, WB_rd} = '0;
        {ID_use_rs1, ID_use_rs2, EX_write_gpr, EX_mem_to_reg, EX_redirect} = '0;
        {ME_write_gpr, ME_mem_to_reg, ME_req, ME_resp_valid} = '0;
        {WB_write_gpr, WB_commit, WB_system_halt} = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_sf(input string name, input logic [4:0] st, input logic [3:0] fl);
        #1;
        check({name, "_stall"}, {27'd0, s_if, s_id, s_ex, s_me, s_wb}, {27'd0, st});
        check({name, "_flush"}, {28'd0, f_if, f_id, f_ex, f_me}, {28'd0, fl});
    endtask

    initial begin
        idle();
        rst = 1'b1;
        ME_req = 1'b1; ME_write_gpr = 1'b1; ME_rd = 5'd7; EX_rs1 = 5'd7;
        repeat (2) cyc();
        chk_sf("reset", 5'b00000, 4'b1111);
        check("reset_rs1_sel", {30'd0, rs1_sel}, 32'd0);
        check("reset_halted", {31'd0, halted}, 32'd0);

        // Memory access completing three cycles after the request.
        cyc(); rst = 1'b0; idle(); ME_req = 1'b1;
        chk_sf("wait0", 5'b11110, 4'b0001);
        cyc(); chk_sf("wait1", 5'b11110, 4'b0001);
        cyc(); chk_sf("wait2", 5'b11110, 4'b0001);
        cyc(); ME_resp_valid = 1'b1; chk_sf("resp", 5'b00000, 4'b0000);
        cyc(); idle(); chk_sf("back_run", 5'b00000, 4'b0000);

        // Load-use, then the bubble in EX.
        cyc(); EX_mem_to_reg = 1'b1; EX_write_gpr = 1'b1; EX_rd = 5'd5;
        ID_rs1 = 5'd5; ID_use_rs1 = 1'b1;
        chk_sf("loaduse", 5'b11000, 4'b0100);
        cyc(); EX_mem_to_reg = 1'b0; EX_write_gpr = 1'b0; EX_rd = 5'd0;
        chk_sf("lu_bubble", 5'b00000, 4'b0000);
        cyc(); EX_mem_to_reg = 1'b1; EX_write_gpr = 1'b1; EX_rd = 5'd5; EX_redirect = 1'b1;
        chk_sf("redir_lu", 5'b00000, 4'b1100);

        // Forwarding selects.
        cyc(); idle(); ME_write_gpr = 1'b1; ME_rd = 5'd7; WB_write_gpr = 1'b1; WB_rd = 5'd7;
        EX_rs1 = 5'd7; #1;
        check("fwd_me", {30'd0, rs1_sel}, 32'd1);
        cyc(); ME_rd = 5'd0; WB_rd = 5'd0; EX_rs2 = 5'd0; #1;
        check("fwd_x0", {30'd0, rs2_sel}, 32'd0);
        cyc(); ME_mem_to_reg = 1'b1; ME_rd = 5'd3; WB_rd = 5'd3; EX_rs2 = 5'd3; #1;
        check("fwd_wb", {30'd0, rs2_sel}, 32'd2);

        // Timeout after TMO wait cycles, then reset mid-wait.
        cyc(); idle(); ME_req = 1'b1; #1;
        check("to_entry", {31'd0, mem_timeout}, 32'd0);
        for (int i = 1; i <= TMO; i++) begin
            cyc(); #1;
            check("to_early", {31'd0, mem_timeout}, 32'd0);
        end
        cyc(); #1; check("to_pulse", {31'd0, mem_timeout}, 32'd1);
        cyc(); #1; check("to_after", {31'd0, mem_timeout}, 32'd0);
        chk_sf("to_still_wait", 5'b11110, 4'b0001);
        cyc(); rst = 1'b1; chk_sf("to_rst", 5'b00000, 4'b1111);
        cyc(); rst = 1'b0; idle(); chk_sf("to_run", 5'b00000, 4'b0000);

        // Halt committed during a memory wait.
        cyc(); ME_req = 1'b1;
        cyc(); WB_commit = 1'b1; WB_system_halt = 1'b1;
        cyc(); WB_commit = 1'b0; WB_system_halt = 1'b0; ME_resp_valid = 1'b1;
        chk_sf("halt", 5'b11111, 4'b0001);
        check("halted_flag", {31'd0, halted}, 32'd1);
        cyc(); chk_sf("halt_hold", 5'b11111, 4'b0001);
        cyc(); rst = 1'b1; idle();
        cyc(); rst = 1'b0;

        // Randomized traffic checked by the model.
        for (int n = 0; n < 3000; n++) begin
            cyc();
            rst            = ($urandom_range(63) == 0);
            ID_rs1         = 5'($urandom_range(7));
            ID_rs2         = 5'($urandom_range(7));
            EX_rs1         = 5'($urandom_range(7));
            EX_rs2         = 5'($urandom_range(7));
            EX_rd          = 5'($urandom_range(7));
            ME_rd          = 5'($urandom_range(7));
            WB_rd          = 5'($urandom_range(7));
            ID_use_rs1     = 1'($urandom_range(1));
            ID_use_rs2     = 1'($urandom_range(1));
            EX_write_gpr   = 1'($urandom_range(1));
            EX_mem_to_reg  = 1'($urandom_range(1));
            EX_redirect    = ($urandom_range(5) == 0);
            ME_write_gpr   = 1'($urandom_range(1));
            ME_mem_to_reg  = 1'($urandom_range(1));
            ME_req         = 1'($urandom_range(1));
            ME_resp_valid  = ($urandom_range(3) == 0);
            WB_write_gpr   = 1'($urandom_range(1));
            WB_commit      = 1'($urandom_range(1));
            WB_system_halt = ($urandom_range(199) == 0);
        end
        cyc();
        idle();
        rst = 1'b1;
        repeat (2) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
